pipelined_fma_aligner: RTL and testbench

//  Two-stage pipelined addend aligner for the FMA datapath (A + B*C), parametrised in format.

---
 rtl/pipelined_fma_aligner.sv | 188 ++++++++++++++++++
 tb/tb_pipelined_fma_aligner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_fma_aligner.sv
// rtl/pipelined_fma_aligner.sv - two-stage FMA addend aligner with valid/ready handshakes (optional skid: ALIGNER_SKID_EN)
module pipelined_fma_aligner #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_BIAS = 127
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     A_sign_i,
    input  logic                     B_sign_i,
    input  logic                     C_sign_i,
    input  logic [PARM_EXP-1:0]      A_Exp_i,
    input  logic [PARM_EXP-1:0]      B_Exp_i,
    input  logic [PARM_EXP-1:0]      C_Exp_i,
    input  logic [PARM_MANT:0]       A_Mant_i,
    input  logic [2*PARM_MANT+2:0]   Wallace_sum_i,
    input  logic [2*PARM_MANT+2:0]   Wallace_carry_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     Sub_o,
    output logic [3*PARM_MANT+5:0]   A_Mant_aligned_o,
    output logic [PARM_EXP+1:0]      Exp_aligned_o,
    output logic                     Sign_aligned_o,
    output logic                     Exp_mv_sign_o,
    output logic                     Mv_halt_o,
    output logic                     Mant_sticky_o,
    output logic [2*PARM_MANT+2:0]   PP_sum_o,
    output logic [2*PARM_MANT+2:0]   PP_carry_o
);
    localparam int W  = 3*PARM_MANT + 6;
    localparam int SH = PARM_MANT + 4;
    localparam int E  = PARM_EXP + 2;
    localparam int PW = 2*PARM_MANT + 3;
    localparam int MW = PARM_MANT + 1;

    localparam logic [E-1:0] BIAS_E   = E'(PARM_BIAS);
    localparam logic [E-1:0] SH_E     = E'(SH);
    localparam logic [E-1:0] HALT_LIM = E'(W - 2);

    typedef struct packed {
        logic          sub;
        logic          sign;
        logic          mv_sign;
        logic          halt;
        logic          sticky;
        logic [E-1:0]  exp;
        logic [W-1:0]  mant;
        logic [PW-1:0] sum;
        logic [PW-1:0] carry;
    } s2_t;

    // Exponent arithmetic in E-bit two's complement; E bits cover every reachable difference.
    logic [E-1:0] a_exp_e, b_exp_e, c_exp_e, d_e, mv_e, prod_exp_e;
    assign a_exp_e    = E'(A_Exp_i);
    assign b_exp_e    = E'(B_Exp_i);
    assign c_exp_e    = E'(C_Exp_i);
    assign d_e        = a_exp_e - b_exp_e - c_exp_e + BIAS_E;
    assign mv_e       = SH_E - d_e;
    assign prod_exp_e = b_exp_e + c_exp_e - BIAS_E + SH_E;

    logic          s1_valid, s1_sub, s1_sign;
    logic [E-1:0]  s1_mv, s1_a_exp, s1_prod_exp;
    logic [MW-1:0] s1_mant;
    logic [PW-1:0] s1_sum, s1_carry;

    logic s2_valid;
    s2_t  s2_q, s2_d, out_q;
    logic s1_can_load, s2_can_load;

    // The mantissa sits at the top of the window; the lower W bits catch what the shift drops.
    logic [W-1:0]   placed;
    logic [2*W-1:0] shifted;
    assign placed  = {s1_mant, {(W-MW){1'b0}}};
    assign shifted = {placed, {W{1'b0}}} >> s1_mv;

`ifdef ALIGNER_SKID_EN
    logic skid_valid;
    s2_t  skid_q;
    // Pipeline stalls only on the registered skid state, so ready_o has no path from ready_i.
    assign s2_can_load = ~s2_valid | ~skid_valid;
    assign valid_o     = s2_valid | skid_valid;
    assign out_q       = skid_valid ? skid_q : s2_q;

    // Skid catches the S2 beat that downstream refused while the pipeline kept moving.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else begin
            if (flush_i)
                skid_valid <= 1'b0;
            else if (skid_valid)
                skid_valid <= ~ready_i;
            else if (s2_valid && !ready_i)
                skid_valid <= 1'b1;
            if (!skid_valid && s2_valid && !ready_i)
                skid_q <= s2_q;
        end
    end
`else
    assign s2_can_load = ~s2_valid | ready_i;
    assign valid_o     = s2_valid;
    assign out_q       = s2_q;
`endif

    assign s1_can_load = ~s1_valid | s2_can_load;
    assign ready_o     = s1_can_load;

    // Stage 1: register exponent difference, shift amount and pass-through operands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid    <= 1'b0;
            s1_sub      <= 1'b0;
            s1_sign     <= 1'b0;
            s1_mv       <= '0;
            s1_a_exp    <= '0;
            s1_prod_exp <= '0;
            s1_mant     <= '0;
            s1_sum      <= '0;
            s1_carry    <= '0;
        end else begin
            if (flush_i)
                s1_valid <= 1'b0;
            else if (s1_can_load)
                s1_valid <= valid_i;
            if (s1_can_load && valid_i) begin
                s1_sub      <= A_sign_i ^ B_sign_i ^ C_sign_i;
                s1_sign     <= A_sign_i;
                s1_mv       <= mv_e;
                s1_a_exp    <= a_exp_e;
                s1_prod_exp <= prod_exp_e;
                s1_mant     <= A_Mant_i;
                s1_sum      <= Wallace_sum_i;
                s1_carry    <= Wallace_carry_i;
            end
        end
    end

    // Stage 2 next value: pick no-shift, shift-with-sticky or out-of-range by the sign and size of mv.
    always_comb begin
        s2_d       = '0;
        s2_d.sub   = s1_sub;
        s2_d.sign  = s1_sign;
        s2_d.sum   = s1_sum;
        s2_d.carry = s1_carry;
        if (s1_mv[E-1]) begin
            s2_d.mv_sign = 1'b1;
            s2_d.mant    = placed;
            s2_d.exp     = s1_a_exp;
        end else if (s1_mv > HALT_LIM) begin
            s2_d.halt   = 1'b1;
            s2_d.sticky = |s1_mant;
            s2_d.exp    = s1_prod_exp;
        end else begin
            s2_d.mant   = shifted[2*W-1:W];
            s2_d.sticky = |shifted[W-1:0];
            s2_d.exp    = s1_prod_exp;
        end
    end

    // Stage 2: register the aligned result whenever the slot is free or being drained.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else begin
            if (flush_i)
                s2_valid <= 1'b0;
            else if (s2_can_load)
                s2_valid <= s1_valid;
            if (s2_can_load && s1_valid)
                s2_q <= s2_d;
        end
    end

    assign Sub_o            = out_q.sub;
    assign Sign_aligned_o   = out_q.sign;
    assign Exp_mv_sign_o    = out_q.mv_sign;
    assign Mv_halt_o        = out_q.halt;
    assign Mant_sticky_o    = out_q.sticky;
    assign Exp_aligned_o    = out_q.exp;
    assign A_Mant_aligned_o = out_q.mant;
    assign PP_sum_o         = out_q.sum;
    assign PP_carry_o       = out_q.carry;
endmodule

// File: tb/tb_pipelined_fma_aligner.sv
// tb/tb_pipelined_fma_aligner.sv - randomized self-checking bench for pipelined_fma_aligner
module tb_pipelined_fma_aligner;
`ifdef ALIGNER_SKID_EN
    localparam int CAP = 3;
`else
    localparam int CAP = 2;
`endif

    typedef struct packed {
        logic        as, bs, cs;
        logic [7:0]  ae, be, ce;
        logic [23:0] am;
        logic [48:0] ws, wc;
    } op_t;

    typedef struct packed {
        logic        sub, sign, mv_sign, halt, sticky;
        logic [9:0]  exp;
        logic [74:0] mant;
        logic [48:0] sum, carry;
    } res_t;

    typedef struct {
        res_t r;
        int   t;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_ni, flush_i, valid_i, ready_o, ready_i;
    logic        A_sign_i, B_sign_i, C_sign_i;
    logic [7:0]  A_Exp_i, B_Exp_i, C_Exp_i;
    logic [23:0] A_Mant_i;
    logic [48:0] Wallace_sum_i, Wallace_carry_i;
    logic        valid_o, Sub_o, Sign_aligned_o, Exp_mv_sign_o, Mv_halt_o, Mant_sticky_o;
    logic [74:0] A_Mant_aligned_o;
    logic [9:0]  Exp_aligned_o;
    logic [48:0] PP_sum_o, PP_carry_o;

    pipelined_fma_aligner dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .A_sign_i(A_sign_i), .B_sign_i(B_sign_i), .C_sign_i(C_sign_i),
        .A_Exp_i(A_Exp_i), .B_Exp_i(B_Exp_i), .C_Exp_i(C_Exp_i), .A_Mant_i(A_Mant_i),
        .Wallace_sum_i(Wallace_sum_i), .Wallace_carry_i(Wallace_carry_i),
        .valid_o(valid_o), .ready_i(ready_i), .Sub_o(Sub_o), .A_Mant_aligned_o(A_Mant_aligned_o),
        .Exp_aligned_o(Exp_aligned_o), .Sign_aligned_o(Sign_aligned_o), .Exp_mv_sign_o(Exp_mv_sign_o),
        .Mv_halt_o(Mv_halt_o), .Mant_sticky_o(Mant_sticky_o), .PP_sum_o(PP_sum_o), .PP_carry_o(PP_carry_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   in_cnt = 0;
    int   out_cnt = 0;
    ent_t exp_q[$];
    op_t  cur_op;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: the alignment rules in plain integer arithmetic.
    function automatic res_t model(input op_t o);
        res_t        r;
        int          d, mv;
        logic [74:0] placed, one;
        r = '0;
        r.sub = o.as ^ o.bs ^ o.cs;
        r.sign = o.as;
        r.sum = o.ws;
        r.carry = o.wc;
        d = int'(o.ae) - int'(o.be) - int'(o.ce) + 127;
        mv = 27 - d;
        placed = 75'(o.am) << 51;
        one = 75'(1);
        if (mv < 0) begin
            r.mv_sign = 1'b1;
            r.mant = placed;
            r.exp = 10'(o.ae);
        end else begin
            r.exp = 10'(int'(o.be) + int'(o.ce) - 127 + 27);
            if (mv > 73) begin
                r.halt = 1'b1;
                r.mant = '0;
                r.sticky = (o.am != 0);
            end else begin
                r.mant = placed >> mv;
                r.sticky = ((placed & ((one << mv) - one)) != 0);
            end
        end
        return r;
    endfunction

    function automatic res_t dut_pack();
        return {Sub_o, Sign_aligned_o, Exp_mv_sign_o, Mv_halt_o, Mant_sticky_o,
                Exp_aligned_o, A_Mant_aligned_o, PP_sum_o, PP_carry_o};
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  off, a;
        o.as = 1'($urandom_range(1, 0));
        o.bs = 1'($urandom_range(1, 0));
        o.cs = 1'($urandom_range(1, 0));
        o.be = 8'($urandom_range(154, 100));
        o.ce = 8'($urandom_range(154, 100));
        off = int'($urandom_range(170, 0)) - 110;
        a = int'(o.be) + int'(o.ce) - 127 + off;
        if (a < 0) a = 0;
        if (a > 255) a = 255;
        o.ae = 8'(a);
        o.am = {1'b1, 23'($urandom)};
        if ($urandom_range(3, 0) == 0) o.am[15:0] = '0;
        o.ws = 49'({$urandom, $urandom});
        o.wc = 49'({$urandom, $urandom});
        return o;
    endfunction

    function automatic op_t mk_op(input logic [7:0] ae, input logic [23:0] am);
        op_t o;
        o = rand_op();
        o.as = 1'b0; o.bs = 1'b0; o.cs = 1'b0;
        o.ae = ae; o.be = 8'd127; o.ce = 8'd127; o.am = am;
        return o;
    endfunction

    // Per-cycle compare against the model queue: timing, data, ready and handshake bookkeeping.
    task automatic monitor();
        logic exp_v, exp_rdy;
        cyc++;
        if (!rst_ni) begin
            exp_q.delete();
            return;
        end
        exp_v = (exp_q.size() > 0) && (cyc - exp_q[0].t >= 2);
        check("valid_o", 256'(valid_o), 256'(exp_v));
        if (valid_o && exp_q.size() > 0)
            check("out_beat", 256'(dut_pack()), 256'(exp_q[0].r));
        exp_rdy = (exp_q.size() < CAP);
`ifndef ALIGNER_SKID_EN
        exp_rdy = exp_rdy | ready_i;
`endif
        check("ready_o", 256'(ready_o), 256'(exp_rdy));
        if (flush_i) begin
            exp_q.delete();
        end else begin
            if (valid_o && ready_i && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                out_cnt++;
            end
            if (valid_i && ready_o) begin
                exp_q.push_back('{r: model(cur_op), t: cyc});
                in_cnt++;
            end
        end
    endtask

    task automatic step(input logic v, input logic r, input logic f, input op_t o);
        @(posedge clk);
        #1;
        valid_i = v; ready_i = r; flush_i = f;
        cur_op = o;
        A_sign_i = o.as; B_sign_i = o.bs; C_sign_i = o.cs;
        A_Exp_i = o.ae; B_Exp_i = o.be; C_Exp_i = o.ce; A_Mant_i = o.am;
        Wallace_sum_i = o.ws; Wallace_carry_i = o.wc;
        @(negedge clk);
        monitor();
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, rand_op());
    endtask

    // Hand-computed expectations: pin the model, then push the beat through an empty pipeline.
    task automatic directed(input string name, input op_t o, input logic [74:0] w_mant,
                            input logic [9:0] w_exp, input logic [2:0] w_flags);
        res_t m;
        m = model(o);
        check({name, "_model_mant"}, 256'(m.mant), 256'(w_mant));
        check({name, "_model_exp"}, 256'(m.exp), 256'(w_exp));
        check({name, "_model_flags"}, 256'({m.mv_sign, m.halt, m.sticky}), 256'(w_flags));
        drain();
        step(1'b1, 1'b1, 1'b0, o);
        step(1'b0, 1'b1, 1'b0, rand_op());
        check({name, "_early"}, 256'(valid_o), 256'(0));
        step(1'b0, 1'b1, 1'b0, rand_op());
        check({name, "_lat_valid"}, 256'(valid_o), 256'(1));
        check({name, "_mant"}, 256'(A_Mant_aligned_o), 256'(w_mant));
        check({name, "_exp"}, 256'(Exp_aligned_o), 256'(w_exp));
        check({name, "_flags"}, 256'({Exp_mv_sign_o, Mv_halt_o, Mant_sticky_o}), 256'(w_flags));
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 256'(valid_o), 256'(0));
        check("arst_data", 256'(dut_pack()), 256'(0));
        @(negedge clk);
        monitor();
        @(posedge clk);
        #3;
        rst_ni = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        monitor();
        check("arst_ready", 256'(ready_o), 256'(1));
    endtask

    logic        pat[4];
    logic [74:0] w;
    int          base_in, base_out;

    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        cur_op = rand_op();
        A_sign_i = 1'b0; B_sign_i = 1'b0; C_sign_i = 1'b0;
        A_Exp_i = '0; B_Exp_i = '0; C_Exp_i = '0; A_Mant_i = '0;
        Wallace_sum_i = '0; Wallace_carry_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 256'(valid_o), 256'(0));
        check("rst_data", 256'(dut_pack()), 256'(0));
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        #1;
        check("rst_ready", 256'(ready_o), 256'(1));

        w = 75'h800000 << 24;
        directed("one", mk_op(8'd127, 24'h800000), w, 10'd154, 3'b000);
        w = 75'hABCDEF << 51;
        directed("big_a", mk_op(8'd200, 24'hABCDEF), w, 10'd200, 3'b100);
        w = 75'h4000;
        directed("mv60", mk_op(8'd94, 24'h800001), w, 10'd154, 3'b001);
        w = '0;
        directed("halt", mk_op(8'd32, 24'h800001), w, 10'd154, 3'b011);

        // Streaming under a 1,0,0,1 ready pattern.
        drain();
        base_in = in_cnt;
        base_out = out_cnt;
        for (int k = 0; k < 60; k++)
            step((in_cnt - base_in) < 8, pat[k % 4], 1'b0, rand_op());
        check("stream_in", 256'(in_cnt - base_in), 256'(8));
        check("stream_out", 256'(out_cnt - base_out), 256'(8));

        // Flush with two beats in flight plus a simultaneous input.
        drain();
        step(1'b1, 1'b0, 1'b0, rand_op());
        step(1'b1, 1'b0, 1'b0, rand_op());
        check("flush_inflight", 256'(exp_q.size()), 256'(2));
        step(1'b1, 1'b0, 1'b1, rand_op());
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, rand_op());
            check("flush_quiet", 256'(valid_o), 256'(0));
        end
        w = 75'h800000 << 24;
        directed("post_flush", mk_op(8'd127, 24'h800000), w, 10'd154, 3'b000);

        // Random traffic with occasional flushes and one asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
                 $urandom_range(39, 0) == 0, rand_op());
        end

        drain();
        check("final_empty", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
